am_tx_1b: RTL

One-bit AM transmitter, the transmit-direction counterpart of the 1-bit AM receive chain. It accepts signed 16-bit audio samples over a valid/ready handshake and paces them at a fixed audio rate. It forms an unsigned envelope with programmable modulation depth, converts the envelope to a 1-bit gate density with a first-order sigma-delta, and gates a square carrier from a 40-bit NCO. The result is a single RF output pin, which is filtered and driven off-chip, as with the receiver's comparator and PWM pins.

---
 rtl/am_tx_1b.sv | 111 +++++++++++
 1 files changed

// File: rtl/am_tx_1b.sv
// One-bit AM transmitter: paced audio intake, depth-scaled envelope, first-order
// sigma-delta gate density, and a square NCO carrier gated onto a single RF pin.
module am_tx_1b #(
    parameter int SAMPLE_DIV = 1024,
    parameter int PHASE_W    = 40
) (
    input  logic               clk,
    input  logic               RST,
    input  logic               en,
    input  logic [PHASE_W-1:0] phase_inc,
    input  logic [7:0]         mod_depth,
    input  logic [15:0]        audio_in,
    input  logic               audio_valid,
    output logic               audio_ready,
    output logic               sample_tick,
    output logic               underrun,
    output logic [15:0]        env,
    output logic               RF_OUT
);

    localparam int              DIV_W    = $clog2(SAMPLE_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SAMPLE_DIV - 1);

    logic [15:0]        hold_reg;
    logic               hold_full_reg;
    logic [DIV_W-1:0]   div_cnt_reg;
    logic signed [15:0] cur_reg;
    logic signed [24:0] prod_reg;
    logic [15:0]        env_reg;
    logic [15:0]        sd_acc_reg;
    logic               gate_reg;
    logic [PHASE_W-1:0] phase_reg;
    logic               rf_reg;
    logic               tick_reg;
    logic               underrun_reg;

    logic               strobe;
    logic               transfer;
    logic [16:0]        sd_sum;
    logic signed [8:0]  depth_s;

    assign strobe   = en && (div_cnt_reg == DIV_LAST);
    assign transfer = audio_valid && !hold_full_reg;
    assign sd_sum   = {1'b0, sd_acc_reg} + {1'b0, env_reg};
    assign depth_s  = $signed({1'b0, mod_depth});

    // Holding register, current sample and the sticky underrun flag.
    // A consuming strobe and a transfer cannot coincide since ready is low while full.
    always_ff @(posedge clk) begin
        if (RST) begin
            hold_reg      <= '0;
            hold_full_reg <= 1'b0;
            cur_reg       <= '0;
            underrun_reg  <= 1'b0;
            tick_reg      <= 1'b0;
        end else begin
            tick_reg <= strobe;
            if (strobe && hold_full_reg) begin
                cur_reg       <= $signed(hold_reg);
                hold_full_reg <= 1'b0;
            end else if (transfer) begin
                hold_reg      <= audio_in;
                hold_full_reg <= 1'b1;
            end
            if (strobe && !hold_full_reg) begin
                underrun_reg <= 1'b1;
            end
        end
    end

    // Envelope: 16x9 signed product, then offset by mid-scale after an arithmetic /256.
    always_ff @(posedge clk) begin
        if (RST) begin
            prod_reg <= '0;
            env_reg  <= 16'h8000;
        end else begin
            prod_reg <= cur_reg * depth_s;
            env_reg  <= 16'h8000 + prod_reg[23:8];
        end
    end

    // Rate divider, NCO and sigma-delta all freeze together while en is low.
    always_ff @(posedge clk) begin
        if (RST) begin
            div_cnt_reg <= '0;
            phase_reg   <= '0;
            sd_acc_reg  <= '0;
            gate_reg    <= 1'b0;
        end else if (en) begin
            div_cnt_reg <= (div_cnt_reg == DIV_LAST) ? '0 : div_cnt_reg + 1'b1;
            phase_reg   <= phase_reg + phase_inc;
            gate_reg    <= sd_sum[16];
            sd_acc_reg  <= sd_sum[15:0];
        end
    end

    always_ff @(posedge clk) begin
        if (RST) begin
            rf_reg <= 1'b0;
        end else begin
            rf_reg <= en & gate_reg & phase_reg[PHASE_W-1];
        end
    end

    assign audio_ready = !hold_full_reg;
    assign sample_tick = tick_reg;
    assign underrun    = underrun_reg;
    assign env         = env_reg;
    assign RF_OUT      = rf_reg;

endmodule
